// File: rtl/integrate_dump.sv
// integrate_dump: integrate-and-dump decimator.
// Sums each group of N unsigned samples from a valid/ready input stream and
// emits one (sum, count) word per group on a valid/ready output stream.
// A level-sensitive flush dumps a short group early.
// Optional feature macro: INTDUMP_MEAN_EN adds out_mean, the rounded mean of
// the emitted group, registered alongside out_sum.
module integrate_dump #(
  parameter  int DW = 16,
  parameter  int N  = 8,
  localparam int SW = DW + $clog2(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef INTDUMP_MEAN_EN
  output logic [DW-1:0] out_mean,
`endif
  output logic [SW-1:0] out_sum,
  output logic [CW-1:0] out_cnt
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (N < 2 || N > 256) begin : g_bad_n
    $error("integrate_dump: N must lie in 2..256");
  end

  // Running group state
  logic [SW-1:0] acc;
  logic [CW-1:0] cnt;

  // Handshake / next-word terms
  logic          slot_free;
  logic          dump_wanted;
  logic          take;
  logic          dump;
  logic [SW-1:0] grp_sum;
  logic [CW-1:0] grp_cnt;

  // Input acceptance and dump decision; the out_ready -> in_ready path is
  // combinational on purpose so a freed slot admits the completing sample
  // in the same cycle.
  always_comb begin
    slot_free   = !out_valid || out_ready;
    dump_wanted = (cnt == LAST) || flush;
    in_ready    = !(dump_wanted && !slot_free);
    take        = in_valid && in_ready;
    grp_sum     = acc + (take ? SW'(in_data) : '0);
    grp_cnt     = cnt + CW'(take);
    dump        = ((take && (cnt == LAST)) || (flush && (grp_cnt != '0)))
                  && slot_free;
  end

`ifdef INTDUMP_MEAN_EN
  localparam int LOG2N = $clog2(N);

  if ((N & (N - 1)) != 0) begin : g_bad_pow2
    $error("integrate_dump: INTDUMP_MEAN_EN requires N to be a power of two");
  end

  // Rounded mean (s + c/2) / c; full groups divide by shifting, short
  // groups fall back to a true divider. The result always fits in DW bits
  // because the mean of DW-bit samples cannot exceed 2^DW-1.
  function automatic logic [DW-1:0] round_mean(input logic [SW-1:0] s,
                                               input logic [CW-1:0] c);
    logic [SW:0] num;
    num = {1'b0, s} + (SW+1)'(c >> 1);
    if (c == '0)
      round_mean = '0;
    else if (c == CW'(N))
      round_mean = DW'(num >> LOG2N);
    else
      round_mean = DW'(num / (SW+1)'(c));
  endfunction

  logic [DW-1:0] mean_next;

  // Mean of the word about to be loaded
  always_comb begin
    mean_next = round_mean(grp_sum, grp_cnt);
  end

  // Mean register, loaded together with out_sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_mean <= '0;
    else if (dump)
      out_mean <= mean_next;
  end
`endif

  // Accumulator, group counter and output word register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cnt   <= '0;
    end else if (dump) begin
      out_sum   <= grp_sum;
      out_cnt   <= grp_cnt;
      out_valid <= 1'b1;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      if (take) begin
        acc <= grp_sum;
        cnt <= grp_cnt;
      end
      if (out_valid && out_ready)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_integrate_dump.sv
// Self-checking bench for integrate_dump (DW=16, N=8): directed scenarios
// with literal expectations plus randomized traffic against a group-level
// reference model. Define INTDUMP_MEAN_EN to also check out_mean.
module tb_integrate_dump;
  localparam int DW = 16;
  localparam int N  = 8;
  localparam int SW = 19;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic [CW-1:0] out_cnt;
`ifdef INTDUMP_MEAN_EN
  logic [DW-1:0] out_mean;
`endif

  integrate_dump #(.DW(DW), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef INTDUMP_MEAN_EN
    .out_mean  (out_mean),
`endif
    .out_sum   (out_sum),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: the group being collected and the word on offer.
  longint g_sum;
  int     g_cnt;
  bit     m_ov;
  longint m_sum;
  int     m_cnt;

  function automatic bit model_ready();
    bit closing;
    closing = (g_cnt == N - 1) || flush;
    return !(closing && m_ov && !out_ready);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      g_sum = 0; g_cnt = 0; m_ov = 0; m_sum = 0; m_cnt = 0;
    end else begin
      bit     tk, closes, free;
      longint ns;
      int     nc;
      tk     = in_valid && model_ready();
      ns     = g_sum + (tk ? longint'(in_data) : 0);
      nc     = g_cnt + (tk ? 1 : 0);
      closes = (nc == N) || (flush && nc > 0);
      free   = !m_ov || out_ready;
      if (closes && free) begin
        m_ov = 1; m_sum = ns; m_cnt = nc; g_sum = 0; g_cnt = 0;
      end else begin
        if (tk) begin g_sum = ns; g_cnt = nc; end
        if (m_ov && out_ready) m_ov = 0;
      end
    end
  end

  // Words actually accepted from the DUT, for the literal expectations.
  longint cap_sum[$];
  int     cap_cnt[$];
  int     cap_mean[$];

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      cap_sum.push_back(longint'(out_sum));
      cap_cnt.push_back(int'(out_cnt));
`ifdef INTDUMP_MEAN_EN
      cap_mean.push_back(int'(out_mean));
`else
      cap_mean.push_back(0);
`endif
    end
  end

  // Per-cycle comparison against the model.
  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("in_ready", in_ready, model_ready());
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
        chk("out_sum", out_sum, m_sum);
        chk("out_cnt", out_cnt, m_cnt);
`ifdef INTDUMP_MEAN_EN
        chk("out_mean", out_mean, (m_sum + m_cnt / 2) / m_cnt);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = DW'(d);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic clear_cap();
    cap_sum.delete(); cap_cnt.delete(); cap_mean.delete();
  endtask

  task automatic expect_word(input string name, input int idx,
                             input longint s, input int c);
    chk({name, "_sum"}, (cap_sum.size() > idx) ? cap_sum[idx] : -1, s);
    chk({name, "_cnt"}, (cap_cnt.size() > idx) ? cap_cnt[idx] : -1, c);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int takes;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    step(); step();
    rst = 1'b0;
    cmp_en = 1;

    // Two full groups back to back, consumer always ready
    clear_cap();
    for (int d = 1; d <= 16; d++) send(d);
    step(); step();
    chk("t1_words", cap_sum.size(), 2);
    expect_word("t1_w0", 0, 36, 8);
    expect_word("t1_w1", 1, 100, 8);

    // Stalled consumer with saturated samples
    clear_cap();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hFFFF;
    takes = 0;
    repeat (20) begin
      @(negedge clk);
      if (in_ready) takes++;
      @(posedge clk);
      #1;
    end
    chk("t2_takes", takes, 15);
    chk("t2_held_valid", out_valid, 1);
    chk("t2_held_sum", out_sum, 20'h7FFF8);
    chk("t2_none_yet", cap_sum.size(), 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_ready_release", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    step(); step();
    chk("t2_words", cap_sum.size(), 2);
    expect_word("t2_w0", 0, 20'h7FFF8, 8);
    expect_word("t2_w1", 1, 20'h7FFF8, 8);

    // Flush with no sample in the flush cycle
    clear_cap();
    send(5); send(6); send(7);
    flush = 1'b1; step(); flush = 1'b0;
    step(); step();
    chk("t3_words", cap_sum.size(), 1);
    expect_word("t3_w0", 0, 18, 3);

    // Flush together with a sample
    clear_cap();
    send(10); send(20);
    flush = 1'b1; send(4); flush = 1'b0;
    step(); step();
    chk("t4_words", cap_sum.size(), 1);
    expect_word("t4_w0", 0, 34, 3);

    // Flush on an empty group produces nothing
    clear_cap();
    repeat (3) begin flush = 1'b1; step(); flush = 1'b0; step(); end
    chk("t5_words", cap_sum.size(), 0);
    chk("t5_valid", out_valid, 0);

    // Reset mid-group
    send(100); send(100); send(100);
    #2 rst = 1'b1;
    #1 chk("t6_rst_valid", out_valid, 0);
    step(); rst = 1'b0;
    clear_cap();
    for (int i = 0; i < 8; i++) send(2);
    step(); step();
    chk("t6_words", cap_sum.size(), 1);
    expect_word("t6_w0", 0, 16, 8);

    // Reset while a word is stalled
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(1);
    step();
    chk("t7_pending", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_valid", out_valid, 0);
    chk("t7_rst_sum", out_sum, 0);
    step(); rst = 1'b0; out_ready = 1'b1;
    clear_cap();
    for (int i = 0; i < 8; i++) send(3);
    step(); step();
    chk("t7_words", cap_sum.size(), 1);
    expect_word("t7_w0", 0, 24, 8);

`ifdef INTDUMP_MEAN_EN
    clear_cap();
    for (int d = 1; d <= 8; d++) send(d);
    step(); step();
    chk("mean_full", (cap_mean.size() > 0) ? cap_mean[0] : -1, 5);
    clear_cap();
    send(1); send(2);
    flush = 1'b1; step(); flush = 1'b0;
    step(); step();
    chk("mean_short", (cap_mean.size() > 0) ? cap_mean[0] : -1, 2);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      if ($urandom_range(0, 7) == 0) in_data = 16'hFFFF;
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    step(); step();
    flush = 1'b0;
    step(); step();
    chk("drain_valid", out_valid, 0);

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/integrate_dump.md
Name: integrate_dump

Overview:
- Downstream consumer stage for the accumulator blocks: integrate-and-dump decimator.
- Accepts a valid/ready stream of unsigned samples, sums each group of N samples, then emits one sum word per group on an output valid/ready stream.
- Supports early flush of a partial group.
- Output holds until the consumer accepts it; a stalled output back-pressures the input.

Parameters:
- DW, 16, input sample width in bits.
- N, 8, samples per group; legal range 2..256.
- SW, DW+$clog2(N), derived localparam, not overridable: sum width; no overflow is possible.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  sample accepted this cycle when in_valid && in_ready.
- in_data  in  DW  unsigned sample.
- flush  in  1  dump the current group at the end of this cycle, even if short.
- out_valid  out  1  sum word present.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_sum  out  SW  group sum.
- out_cnt  out  $clog2(N+1)  number of samples in out_sum; N for a full group, 1..N-1 after a flush.

Behaviour:
- Reset (asynchronous, active-high): acc=0, cnt=0, out_valid=0, out_sum=0, out_cnt=0. in_ready is combinational and reads 1 after reset.
- Internal state: acc (SW bits, running sum) and cnt (samples in acc). There is no separate FSM: the two phases are COLLECT (out_valid=0) and PENDING (out_valid=1). Collection continues while PENDING.
- Handshake signals:
  - take = in_valid && in_ready.
  - dump = (take && cnt==N-1) || (flush && (cnt + take) > 0).
  - slot_free = !out_valid || out_ready.
- in_ready = !(dump_wanted && !slot_free), where dump_wanted is dump evaluated assuming take=1.
  - A non-completing sample is always accepted.
  - The completing sample, or any sample arriving while flush=1, is held off while the output is stalled.
  - This is a combinational path from out_ready to in_ready and is intentional.
- On dump with slot_free, at the next edge:
  - out_sum <= acc + (take ? in_data : 0).
  - out_cnt <= cnt + take.
  - out_valid <= 1.
  - acc <= 0, cnt <= 0.
- On take without dump: acc <= acc + in_data, cnt <= cnt + 1.
- Output accepted with no new dump: out_valid <= 0. out_sum and out_cnt retain their last value.
- Output accepted and new dump in the same cycle: out_valid stays 1 and the new word loads. This gives back-to-back words with no bubble.
- flush with cnt==0 and no take: ignored; no zero-count word is ever produced.
- flush while the output is stalled with a partial group pending: no dump, acc and cnt are unchanged. The upstream must hold flush until it takes effect (flush is level-sensitive).
- Latency: the completing sample is accepted in cycle t; out_valid=1 in cycle t+1.
- Throughput: one sample per cycle sustained while out_ready=1.
- Arithmetic: unsigned, zero-extended to SW. The maximum sum N*(2^DW-1) fits in SW.
- Reset asserted mid-group or mid-pending: the partial sum and any pending word are discarded immediately.

Optional Feature:
- Macro: INTDUMP_MEAN_EN.
- When defined:
  - Adds output out_mean, DW bits: the rounded mean of the group, = (out_sum + out_cnt/2) / out_cnt.
  - Registered together with out_sum, so it has the same timing as out_valid.
  - For full groups with N a power of two, it is computed by shift. For partial groups, a combinational divider by out_cnt is used.
  - N must be a power of two; elaboration fails otherwise.
- When undefined: the port and all its logic are absent.

Test Plan:
- N=8, DW=16, out_ready=1, samples 1..16 back-to-back
  -> two words, (36,8) then (100,8), each 1 cycle after its 8th sample; in_ready stays 1 throughout.
- out_ready=0 for 20 cycles while feeding 0xFFFF continuously
  -> first word 0x7FFF8, cnt 8, held stable; 7 further samples accepted; in_ready=0 on the 8th until out_ready=1; second word 0x7FFF8 follows on the next cycle.
- Feed 5,6,7, then flush=1 with in_valid=0
  -> word (18,3); cnt returns to 0.
- flush=1 together with in_valid=1, data=4, after samples 10,20
  -> word (34,3).
- flush pulses with cnt==0 and no sample
  -> no output word.
- Assert rst mid-group after 3 samples and during a stalled pending word
  -> out_valid drops asynchronously; next group after release sums from 0.
- INTDUMP_MEAN_EN, samples 1..8 -> out_mean=5. Flush after 1,2 -> out_mean=2.
